mux_arb: RTL and testbench

- Parametrised, registered C-channel arbitrated multiplexer; next generation of the team's fixed-select mux family (mux2/mux4/mux8).
- Each input channel is a valid/ready stream. The block picks one channel per transfer and presents the selected word on a single registered output stream.
- Two modes:
  - FIXED: the select input chooses the channel, as in the combinational muxes.
  - RR: round-robin arbitration among the valid channels.
- Sits between multiple producers (e.g. per-source FIFOs) and one shared consumer.

---
 rtl/mux_pkg.sv | 40 ++++
 rtl/mux_arb_rr_pick.sv | 55 +++++
 rtl/mux_arb.sv | 141 ++++++++++++++
 tb/tb_mux_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared types and helpers for the mux_arb arbitrated multiplexer.
//   - mux_mode_t : channel selection policy (FIXED select or round-robin).
//   - chan_slice : extracts channel i from a flattened C*N bus.
//   - next_ptr   : round-robin pointer successor with wrap at C-1.
//   The slice helper works on buses up to MAX_C channels of MAX_N bits each.
// -----------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  localparam int MAX_C     = 32;
  localparam int MAX_N     = 256;
  localparam int MAX_BUS_W = MAX_C * MAX_N;

  // Returns bits [idx*width +: width] of bus, zero-extended to MAX_N bits.
  // Called with constant idx/width, it reduces to plain wiring.
  function automatic logic [MAX_N-1:0] chan_slice(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   idx,
    input int                   width
  );
    logic [MAX_N-1:0] word;
    word = '0;
    for (int b = 0; b < MAX_N; b++) begin
      if (b < width) word[b] = bus[idx*width + b];
    end
    return word;
  endfunction

  // Round-robin successor: the channel after g, wrapping to 0 after c-1.
  function automatic int next_ptr(input int g, input int c);
    return (g == c - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Grants the first requesting
//   channel found when searching ptr, ptr+1, ..., C-1, 0, ..., ptr-1.
//
//   Ports:
//     req       in  C      per-channel request
//     ptr       in  SEL_W  search start index (values >= C behave as 0)
//     gnt_valid out 1      at least one request is present
//     gnt_idx   out SEL_W  granted channel index (0 when gnt_valid=0)
//
//   Method: the request vector is doubled ({req, req}) and shifted right by
//   ptr, so bit j of the low C bits is req[(ptr+j) mod C]. A lowest-bit
//   priority encoder finds the offset j, and ptr+j is folded back below C
//   by subtracting C, which keeps the wrap correct when C is not a power of 2.
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter  int C     = 8,
  localparam int SEL_W = $clog2(C)
) (
  input  logic [C-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [SEL_W-1:0] ptr_eff;
  logic [C-1:0]     rot_req;
  logic [SEL_W-1:0] offset;
  logic [SEL_W:0]   sum;

  // NOTE: every variable driven here gets a default before any condition so
  // no path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    offset    = '0;
    gnt_idx   = '0;

    ptr_eff = (int'(ptr) < C) ? ptr : '0;
    rot_req = C'({req, req} >> ptr_eff);

    // Scan downwards so the lowest set bit (nearest to ptr) wins.
    for (int j = C - 1; j >= 0; j--) begin
      if (rot_req[j]) begin
        gnt_valid = 1'b1;
        offset    = SEL_W'(j);
      end
    end

    sum = {1'b0, ptr_eff} + {1'b0, offset};
    if (int'(sum) >= C) gnt_idx = SEL_W'(int'(sum) - C);
    else                gnt_idx = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/mux_arb.sv
// -----------------------------------------------------------------------------
// mux_arb
//   Registered C-channel arbitrated multiplexer. Each input channel is a
//   valid/ready stream; one channel is granted per transfer and its word is
//   captured in a single output register stage. Either the switch input
//   selects the channel (FIXED) or a round-robin arbiter picks among the
//   valid channels (RR). With out_ready held high one word per cycle flows.
//
//   Parameters:
//     N      data width per channel (<= 256)
//     C      channel count, 2..32, any value
//     SEL_W  derived index width, $clog2(C)
//
//   Ports:
//     clk        in  1      rising-edge clock
//     rst        in  1      synchronous reset, active low
//     mode       in  1      0 = FIXED, 1 = RR
//     switch     in  SEL_W  channel select in FIXED mode (>= C never grants)
//     in_data    in  C*N    flattened inputs, channel i at [i*N +: N]
//     in_valid   in  C      per-channel valid
//     in_ready   out C      per-channel ready, combinational, one-hot or zero
//     out_data   out N      registered selected word
//     out_valid  out 1      out_data holds an unconsumed word
//     out_ready  in  1      consumer accepts when out_valid & out_ready
//     out_sel    out SEL_W  channel that produced out_data
// -----------------------------------------------------------------------------
module mux_arb
  import mux_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int C     = 8,
  localparam int SEL_W = $clog2(C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] switch,
  input  logic [C*N-1:0]   in_data,
  input  logic [C-1:0]     in_valid,
  output logic [C-1:0]     in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] out_sel
);

  // Index space of a SEL_W-bit field; entries at or above C are padding.
  localparam int SEL_SPAN = 1 << SEL_W;

  mux_mode_t            mode_e;
  logic                 can_load;
  logic                 load;
  logic [SEL_SPAN-1:0]  valid_pad;
  logic                 fix_valid;
  logic                 rr_valid;
  logic [SEL_W-1:0]     rr_idx;
  logic                 gnt_valid;
  logic [SEL_W-1:0]     gnt_idx;
  logic [SEL_W-1:0]     ptr;
  logic [N-1:0]         chan [SEL_SPAN];

  assign mode_e = mux_mode_t'(mode);

  // The output register can take a new word when it is empty or its current
  // word leaves this cycle; drain and load in the same edge lose nothing.
  assign can_load = ~out_valid | out_ready;

  // Channel words as an array; padding entries read as zero so any index
  // value is safe to look up.
  for (genvar i = 0; i < SEL_SPAN; i++) begin : g_chan
    if (i < C) begin : g_real
      assign chan[i] = N'(chan_slice(MAX_BUS_W'(in_data), i, N));
    end else begin : g_pad
      assign chan[i] = '0;
    end
  end

  // FIXED path: zero-padded valids make switch >= C fall on a 0 bit, so an
  // out-of-range select never grants.
  assign valid_pad = SEL_SPAN'(in_valid);
  assign fix_valid = valid_pad[switch];

  rr_pick #(
    .C (C)
  ) u_rr_pick (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    unique case (mode_e)
      MODE_FIXED: begin
        gnt_valid = fix_valid;
        gnt_idx   = switch;
      end
      MODE_RR: begin
        gnt_valid = rr_valid;
        gnt_idx   = rr_idx;
      end
      default: ;
    endcase
  end

  // A granted channel always has in_valid set, so load equals the handshake.
  assign load = rst & can_load & gnt_valid;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < C; i++) begin
      in_ready[i] = load && (gnt_idx == SEL_W'(i));
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_data  <= chan[gnt_idx];
      out_sel   <= gnt_idx;
      out_valid <= 1'b1;
      // The pointer only moves on RR grants, so it survives FIXED periods.
      if (mode_e == MODE_RR) begin
        ptr <= SEL_W'(next_ptr(int'(gnt_idx), C));
      end
    end else if (out_ready) begin
      // Nothing to load: the held word (if any) drains; data/sel keep their
      // last value, only valid drops.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_arb
//   Self-checking bench for mux_arb with C=5, N=8. A behavioural model tracks
//   the output register and RR pointer; every accepted word is queued and
//   popped when the consumer takes it from the DUT. A vector table covers
//   RR fairness, sparse wrap, FIXED grants and pointer retention; hand-written
//   sequences cover reset, backpressure and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_mux_arb;

  localparam int N     = 8;
  localparam int C     = 5;
  localparam int SEL_W = $clog2(C);

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [SEL_W-1:0] switch;
  logic [C*N-1:0]   in_data;
  logic [C-1:0]     in_valid;
  logic [C-1:0]     in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_sel;

  always #5 clk = ~clk;

  mux_arb #(
    .N (N),
    .C (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .switch    (switch),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  typedef struct packed {
    logic [N-1:0]     data;
    logic [SEL_W-1:0] sel;
  } word_t;

  typedef struct packed {
    logic             mode;
    logic [SEL_W-1:0] sw;
    logic [C-1:0]     valid;
    logic             ordy;
    logic [C-1:0]     exp_rdy;
    logic             exp_ov;
    logic [SEL_W-1:0] exp_sel;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t sb_q[$];

  // Reference model state
  logic  m_ov;
  word_t m_word;
  int    m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [C*N-1:0] base_data();
    logic [C*N-1:0] d;
    for (int i = 0; i < C; i++) d[i*N +: N] = N'(8'h10 + i);
    return d;
  endfunction

  // Expected grant under the current inputs; -1 means none.
  function automatic int model_grant();
    if (mode == 1'b0) begin
      if (int'(switch) < C && in_valid[switch]) return int'(switch);
      return -1;
    end
    for (int k = 0; k < C; k++) begin
      int i;
      i = (m_ptr + k) % C;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, return 1 time unit after it so the caller can drive new inputs.
  task automatic cycle();
    int             g;
    logic           can_load;
    logic [C-1:0]   exp_rdy;
    word_t          w;
    @(negedge clk);
    can_load = !m_ov || out_ready;
    g        = model_grant();
    exp_rdy  = '0;
    if (rst && can_load && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_word.data));
    check("out_sel", 32'(out_sel), 32'(m_word.sel));
    if (rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        w = sb_q.pop_front();
        check("sb_data", 32'(out_data), 32'(w.data));
        check("sb_sel", 32'(out_sel), 32'(w.sel));
      end
    end
    @(posedge clk);
    if (!rst) begin
      m_ov   = 1'b0;
      m_word = '0;
      m_ptr  = 0;
      sb_q.delete();
    end else if (exp_rdy != '0) begin
      m_word.data = in_data[g*N +: N];
      m_word.sel  = SEL_W'(g);
      m_ov        = 1'b1;
      sb_q.push_back(m_word);
      if (mode) m_ptr = (g == C - 1) ? 0 : g + 1;
    end else if (can_load && out_ready) begin
      m_ov = 1'b0;
    end
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    //               mode  sw   valid     ordy exp_rdy   ov   sel
    vecs[0]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
    vecs[1]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1};
    vecs[2]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2};
    vecs[3]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3};
    vecs[4]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b10000, 1'b1, 3'd4};
    vecs[5]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
    vecs[6]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b00010, 1'b1, 3'd1};
    vecs[7]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b00100, 1'b1, 3'd2};
    vecs[8]  = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3};
    vecs[9]  = '{1'b1, 3'd0, 5'b00110, 1'b1, 5'b00010, 1'b1, 3'd1};
    vecs[10] = '{1'b1, 3'd0, 5'b00110, 1'b1, 5'b00100, 1'b1, 3'd2};
    vecs[11] = '{1'b0, 3'd3, 5'b01000, 1'b1, 5'b01000, 1'b1, 3'd3};
    vecs[12] = '{1'b0, 3'd6, 5'b11111, 1'b1, 5'b00000, 1'b0, 3'd3};
    vecs[13] = '{1'b1, 3'd0, 5'b11111, 1'b1, 5'b01000, 1'b1, 3'd3};

    // ---- Reset held with every channel valid
    rst       = 1'b0;
    mode      = 1'b1;
    switch    = '0;
    in_data   = base_data();
    in_valid  = '1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    m_ov   = 1'b0;
    m_word = '0;
    m_ptr  = 0;

    // ---- Table: RR fairness, sparse wrap, FIXED select, ptr retention
    rst = 1'b1;
    for (int v = 0; v < 14; v++) begin
      mode      = vecs[v].mode;
      switch    = vecs[v].sw;
      in_valid  = vecs[v].valid;
      out_ready = vecs[v].ordy;
      #1;
      check($sformatf("vec%0d_rdy", v), 32'(in_ready), 32'(vecs[v].exp_rdy));
      cycle();
      check($sformatf("vec%0d_ov", v), 32'(out_valid), 32'(vecs[v].exp_ov));
      check($sformatf("vec%0d_sel", v), 32'(out_sel), 32'(vecs[v].exp_sel));
    end

    // ---- FIXED select of channel 3 carrying A5, then out-of-range switch
    mode             = 1'b0;
    switch           = 3'd3;
    in_data[3*N +: N] = 8'hA5;
    in_valid         = 5'b01000;
    cycle();
    check("fix_data", 32'(out_data), 32'hA5);
    check("fix_sel", 32'(out_sel), 32'd3);
    switch = 3'd6;
    in_valid = 5'b11111;
    cycle();
    check("fix_oob_ov", 32'(out_valid), 32'd0);

    // ---- Backpressure: load ch4 (ptr is 4), then stall with churning inputs
    in_data  = base_data();
    mode     = 1'b1;
    cycle();
    check("bp_load_sel", 32'(out_sel), 32'd4);
    out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      in_valid = C'($urandom());
      switch   = SEL_W'($urandom());
      in_data  = (C*N)'({$urandom(), $urandom()});
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
      cycle();
      check("bp_hold_data", 32'(out_data), 32'h14);
      check("bp_hold_sel", 32'(out_sel), 32'd4);
    end
    // Release with only ch2 valid: drain and load in one edge
    in_data   = base_data();
    in_valid  = 5'b00100;
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(in_ready), 32'b00100);
    cycle();
    check("bp_nobubble_ov", 32'(out_valid), 32'd1);
    check("bp_nobubble_sel", 32'(out_sel), 32'd2);
    check("bp_nobubble_data", 32'(out_data), 32'h12);

    // ---- Reset mid-stream: word held, ptr is 3
    out_ready = 1'b0;
    in_valid  = 5'b11111;
    rst       = 1'b0;
    #1;
    check("midrst_rdy", 32'(in_ready), 32'd0);
    cycle();
    check("midrst_ov", 32'(out_valid), 32'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("post_rst_sel", 32'(out_sel), 32'd0);
    check("post_rst_ov", 32'(out_valid), 32'd1);

    // ---- Drain the last word and confirm nothing is left outstanding
    in_valid = '0;
    cycle();
    check("final_ov", 32'(out_valid), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
